// File: rtl/fetch_queue_if.sv
// IMEM read port between the fetch queue and the instruction memory.
// The queue is the master: it raises req with addr and holds both until ack, which returns rdata.
interface fetch_queue_if;
   logic        req;
   logic [31:0] addr;
   logic        ack;
   logic [31:0] rdata;

   modport master (output req, addr, input ack, rdata);
   modport slave  (input req, addr, output ack, rdata);
endinterface

// File: rtl/fetch_queue.sv
// Instruction prefetch queue. It owns the fetch PC, keeps at most one IMEM read outstanding,
// and buffers up to DEPTH {pc, instr} entries for the fetch/decode register.
module fetch_queue #(
   parameter int unsigned DEPTH     = 4,
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'hE1A0_0000
) (
   input  logic               clk,
   input  logic               reset,
   fetch_queue_if.master      imem,
   input  logic               redirect,
   input  logic [31:0]        redirect_pc,
   input  logic               stall,
   output logic               instr_valid,
   output logic [31:0]        instr_out,
   output logic [31:0]        pc_out
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      DROP
   } state_t;

   state_t           state;
   state_t           state_nxt;

   logic [31:0]      pc_mem    [DEPTH];
   logic [31:0]      instr_mem [DEPTH];
   logic [PTR_W-1:0] head;
   logic [PTR_W-1:0] tail;
   logic [CNT_W-1:0] count;

   logic [31:0]      fetch_pc;
   logic [31:0]      stale_addr;
   logic             push;
   logic             pop;
   logic             has_room;

   // Head outputs depend on registered state only.
   assign instr_valid = (count != '0);
   assign instr_out   = instr_valid ? instr_mem[head] : NOP_INSTR;
   assign pc_out      = instr_valid ? pc_mem[head]    : 32'h0;

   assign pop      = instr_valid && !stall;
   // A pop this cycle frees a slot in time for the push of the request issued next cycle.
   assign has_room = (count != CNT_W'(DEPTH)) || pop;

   // A request in DROP is still owed to IMEM, so it keeps presenting the pre-redirect address.
   assign imem.req  = (state != IDLE);
   assign imem.addr = (state == DROP) ? stale_addr : fetch_pc;

   // NOTE: every signal written here gets a default first, so no path can infer a latch.
   always_comb begin
      state_nxt = state;
      push      = 1'b0;
      case (state)
         IDLE: begin
            if (has_room && !redirect) state_nxt = REQ;
         end
         REQ: begin
            if (imem.ack) begin
               state_nxt = IDLE;
               push      = !redirect;
            end else if (redirect) begin
               state_nxt = DROP;
            end
         end
         DROP: begin
            if (imem.ack) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         fetch_pc   <= RESET_PC;
         stale_addr <= RESET_PC;
         head       <= '0;
         tail       <= '0;
         count      <= '0;
      end else begin
         state <= state_nxt;

         if (redirect)  fetch_pc <= redirect_pc;
         else if (push) fetch_pc <= fetch_pc + 32'd4;

         if (state == REQ && redirect) stale_addr <= fetch_pc;

         // Redirect flushes and wins over any same-cycle push or pop.
         if (redirect) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
         end else begin
            if (push) tail <= tail + PTR_W'(1);
            if (pop)  head <= head + PTR_W'(1);
            if (push && !pop)      count <= count + CNT_W'(1);
            else if (!push && pop) count <= count - CNT_W'(1);
         end
      end
   end

   // NOTE: entry storage is not reset; count gates every read, so stale contents are never visible.
   always_ff @(posedge clk) begin
      if (push) begin
         pc_mem[tail]    <= fetch_pc;
         instr_mem[tail] <= imem.rdata;
      end
   end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction prefetch queue between the instruction memory and the pipelined datapath's fetch stage. It owns the fetch PC, issues word reads to IMEM with a req/ack handshake, buffers up to DEPTH returned instructions with their addresses, and presents the oldest one to the fetch/decode register. Branch redirects from the datapath flush it, and the hazard unit's StallF holds its output.

## Interface
- DEPTH, 4: queue entries; power of two, 2..16
- RESET_PC, 32'h0000_0000: fetch address after reset
- NOP_INSTR, 32'hE1A0_0000: value driven on instr_out while empty (MOV R0,R0)

- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high; one clock, and reset is synchronous and active-high
- imem_req  output  1  read request to IMEM
- imem_addr  output  32  word address of the request
- imem_ack  input  1  IMEM returns data this cycle; meaningful only while imem_req=1
- imem_rdata  input  32  instruction word, valid with imem_ack
- redirect  input  1  taken branch / PC write from the datapath
- redirect_pc  input  32  new fetch address, sampled with redirect
- stall  input  1  StallF from the hazard unit; blocks pop
- instr_valid  output  1  head entry present
- instr_out  output  32  head instruction, or NOP_INSTR when empty
- pc_out  output  32  address of head instruction (0 when empty)

## Operation
- Storage: circular buffer of DEPTH {pc, instr} entries, head/tail pointers of log2(DEPTH) bits that wrap mod DEPTH, and a count of 0..DEPTH.
- fetch_pc register: reset to RESET_PC; +4 mod 2^32 on each accepted ack; loaded with redirect_pc on redirect.
- FSM states:
  - IDLE: imem_req=0. Goes to REQ when count < DEPTH and redirect=0.
  - REQ: imem_req=1, imem_addr=fetch_pc, both held stable until ack.
    - ack without redirect: push {fetch_pc, imem_rdata}, go to IDLE.
    - redirect without ack: go to DROP.
    - redirect with ack: discard data, go to IDLE.
  - DROP: imem_req=1 with the stale address held; the request is still owed.
    - ack: discard data, go to IDLE.
    - redirect: reloads fetch_pc and stays in DROP.
- Only one request is outstanding at a time. Because count < DEPTH is checked on entry to REQ, a push always fits.
- Pop occurs when instr_valid=1 and stall=0; head advances.
- Push and pop in the same cycle: count unchanged; pointers both advance.
- Redirect flushes the queue: count=0, head=tail=0. It takes priority over any same-cycle push or pop.
- imem_addr in IDLE: drives fetch_pc; IMEM must ignore it since imem_req=0.
- Reset mid-operation: any in-flight request is abandoned.
  - State returns to IDLE, the queue is emptied, and fetch_pc=RESET_PC.
  - A late ack while imem_req=0 is ignored.

## Timing
- Reset values of outputs: imem_req=0, imem_addr=RESET_PC, instr_valid=0, instr_out=NOP_INSTR, pc_out=0.
- Handshake: ack may arrive in the first cycle imem_req is high or any later cycle; there is no timeout.
- Latency with zero-wait IMEM:
  - reset deasserted at cycle 0; REQ (imem_req=1) in cycle 1; ack in cycle 1; instr_valid=1 in cycle 2.
  - Steady-state throughput: one instruction per 2 cycles (IDLE/REQ alternation).
- Redirect at cycle n:
  - instr_valid=0 at n+1.
  - The first request for redirect_pc is REQ at n+2 if no request was owed; otherwise at the cycle after the DROP ack plus one.
- Outputs instr_valid, instr_out and pc_out are functions of registered state only. There is no combinational path from stall, redirect or imem_ack to them.
- Full (count=DEPTH): the FSM stays in IDLE. A pop in cycle n allows REQ at n+1.

## Test plan
- Reset, zero-wait IMEM returning addr-as-data, stall=0: imem_addr sequence 0,4,8,C; instr_out/pc_out pairs (0,0),(4,4),(8,8) on consecutive valid cycles; first valid at cycle 2.
- Hold stall=1 with DEPTH=4: exactly four requests issued (addresses 0..C), imem_req stays 0 afterward, and instr_out stays 0. Release stall for one cycle: one pop, then the next request issued is address 10.
- IMEM with 3 wait cycles: imem_req and imem_addr are held stable for all 4 cycles; a single entry is pushed on ack.
- Redirect to 0x100 during the second wait cycle of a request to 0x8:
  - The queue empties next cycle.
  - The stale ack is discarded; no entry with pc 0x8 appears.
  - The next request is 0x100, and the first valid pc_out is 0x100.
- Redirect, ack and pop in the same cycle with 2 queued entries: next cycle count=0 and instr_valid=0. The next request is redirect_pc, and the acked data never appears.
- Assert reset while in REQ, with ack asserted one cycle after reset: no push occurs, imem_req=0 after reset, and fetching restarts at RESET_PC.
